// File: rtl/hdmi_tile_wr_ctrl_pkg.sv
// hdmi_pkg: register map, CTRL/STATUS bit positions and drain FSM encoding shared by the tile write path.
// No ports; exports byte offsets, bit indices, state_t and apply_strb().
package hdmi_pkg;
   localparam logic [4:0] OFF_ADDR   = 5'h00;
   localparam logic [4:0] OFF_DATA   = 5'h04;
   localparam logic [4:0] OFF_CTRL   = 5'h08;
   localparam logic [4:0] OFF_STATUS = 5'h0C;
   localparam logic [4:0] OFF_USER_U = 5'h10;
   localparam logic [4:0] OFF_USER_D = 5'h14;
   localparam int CTRL_AUTO_INC = 0;
   localparam int CTRL_VB_ONLY  = 1;
   localparam int ST_FULL  = 8;
   localparam int ST_EMPTY = 9;
   localparam int ST_BUSY  = 10;
   typedef enum logic [1:0] {S_IDLE, S_WAIT_VB, S_WRITE} state_t;
   // Byte-strobe merge: strobed bytes come from new_v, the rest keep old_v.
   function automatic logic [31:0] apply_strb(input logic [31:0] old_v, input logic [31:0] new_v,
                                              input logic [3:0] strb);
      logic [31:0] m;
      m = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
      return (old_v & ~m) | (new_v & m);
   endfunction
endpackage

// File: rtl/hdmi_tile_wr_ctrl_if.sv
// hdmi_tile_wr_ctrl_if: PicoRV32 native memory bus toward the tile write controller.
// master = CPU side (drives valid/addr/wdata/wstrb), slave = controller (drives ready/rdata).
interface hdmi_tile_wr_ctrl_if;
   logic        mem_valid;
   logic        mem_ready;
   logic [4:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;
   modport master (output mem_valid, mem_addr, mem_wdata, mem_wstrb, input mem_ready, mem_rdata);
   modport slave  (input mem_valid, mem_addr, mem_wdata, mem_wstrb, output mem_ready, mem_rdata);
endinterface

// File: rtl/hdmi_tile_wr_ctrl_sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO with full/empty/level.
// Ports: clk, rst (async high), push_i/din_i write side, pop_i/dout_o read side (dout_o is the head),
// full_o, empty_o, level_o. A push while full is legal only together with a pop.
module sync_fifo #(
   parameter int W     = 48,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic [W-1:0]             din_i,
   input  logic                     pop_i,
   output logic [W-1:0]             dout_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wp_q, rp_q;
   logic [LW-1:0] level_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp_q    <= '0;
         rp_q    <= '0;
         level_q <= '0;
      end else begin
         wp_q    <= push_i ? wp_q + 1'b1 : wp_q;
         rp_q    <= pop_i ? rp_q + 1'b1 : rp_q;
         level_q <= level_q + LW'(push_i) - LW'(pop_i);
      end
   end
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wp_q] <= din_i;
   end
   assign dout_o  = mem_q[rp_q];
   assign full_o  = level_q == LW'(DEPTH);
   assign empty_o = level_q == '0;
   assign level_o = level_q;
endmodule

// File: rtl/hdmi_tile_wr_ctrl.sv
// hdmi_tile_wr_ctrl: CPU register window that queues tile RAM writes and drains them, optionally only in vblank.
// Ports: sys_clk, rst (async high); bus (native memory bus, slave side); vblank_in (async pixel-domain blank);
// tile_we/tile_addr/tile_data (tile RAM write port); user_block_u/user_block_d; irq_empty (FIFO empty and idle).
module hdmi_tile_wr_ctrl
   import hdmi_pkg::*;
#(
   parameter int ADDR_W     = 16,
   parameter int FIFO_DEPTH = 8,
   parameter int WR_HOLD    = 2
) (
   input  logic                sys_clk,
   input  logic                rst,
   hdmi_tile_wr_ctrl_if.slave  bus,
   input  logic                vblank_in,
   output logic                tile_we,
   output logic [ADDR_W-1:0]   tile_addr,
   output logic [31:0]         tile_data,
   output logic [31:0]         user_block_u,
   output logic [31:0]         user_block_d,
   output logic                irq_empty
);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   localparam int HW = WR_HOLD > 1 ? $clog2(WR_HOLD) : 1;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        ctrl_q, ctrl_d;
   logic [31:0]       user_u_q, user_u_d, user_d_q, user_d_d, rdata_q, rdata_d, status;
   logic              ready_q, vb_meta_q, vb_s_q;
   state_t            state_q;
   logic [HW-1:0]     hold_q;
   logic              tile_we_q;
   logic [ADDR_W-1:0] tile_addr_q;
   logic [31:0]       tile_data_q;
   logic [4:0]        off;
   logic              is_wr, req, data_wr, push, pop, accept, wr, full, empty, busy;
   logic [LW-1:0]     level;
   logic [ADDR_W+31:0] head;
   logic              unused_addr_lsbs;
   assign unused_addr_lsbs = ^bus.mem_addr[1:0];
   assign off     = {bus.mem_addr[4:2], 2'b00};
   assign is_wr   = |bus.mem_wstrb;
   // ready_q masks the ack cycle so a request held through its ack is not taken twice.
   assign req     = bus.mem_valid && !ready_q;
   assign data_wr = req && is_wr && off == OFF_DATA;
   // The drain pops only when it is allowed to write, so a held drain leaves the FIFO full.
   assign pop     = state_q == S_WAIT_VB && !empty && (!ctrl_q[CTRL_VB_ONLY] || vb_s_q);
   assign push    = data_wr && (!full || pop);
   assign accept  = req && !(data_wr && !push);
   assign wr      = accept && is_wr;
   assign busy    = state_q != S_IDLE;
   assign status  = {21'b0, busy, empty, full, 8'(level)};
   always_comb begin
      addr_d   = wr && off == OFF_ADDR ? ADDR_W'(apply_strb(32'(addr_q), bus.mem_wdata, bus.mem_wstrb))
               : push && ctrl_q[CTRL_AUTO_INC] ? addr_q + 1'b1 : addr_q;
      ctrl_d   = wr && off == OFF_CTRL ? 2'(apply_strb({30'b0, ctrl_q}, bus.mem_wdata, bus.mem_wstrb)) : ctrl_q;
      user_u_d = wr && off == OFF_USER_U ? apply_strb(user_u_q, bus.mem_wdata, bus.mem_wstrb) : user_u_q;
      user_d_d = wr && off == OFF_USER_D ? apply_strb(user_d_q, bus.mem_wdata, bus.mem_wstrb) : user_d_q;
      rdata_d  = !accept || is_wr     ? 32'b0
               : off == OFF_ADDR      ? 32'(addr_q)
               : off == OFF_CTRL      ? {30'b0, ctrl_q}
               : off == OFF_STATUS    ? status
               : off == OFF_USER_U    ? user_u_q
               : off == OFF_USER_D    ? user_d_q : 32'b0;
   end
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         addr_q    <= '0;
         ctrl_q    <= '0;
         user_u_q  <= '0;
         user_d_q  <= '0;
         rdata_q   <= '0;
         ready_q   <= 1'b0;
         vb_meta_q <= 1'b0;
         vb_s_q    <= 1'b0;
      end else begin
         addr_q    <= addr_d;
         ctrl_q    <= ctrl_d;
         user_u_q  <= user_u_d;
         user_d_q  <= user_d_d;
         rdata_q   <= rdata_d;
         ready_q   <= accept;
         vb_meta_q <= vblank_in;
         vb_s_q    <= vb_meta_q;
      end
   end
   sync_fifo #(.W(ADDR_W + 32), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (sys_clk),
      .rst     (rst),
      .push_i  (push),
      .din_i   ({addr_q, bus.mem_wdata}),
      .pop_i   (pop),
      .dout_o  (head),
      .full_o  (full),
      .empty_o (empty),
      .level_o (level)
   );
   // Once WRITE is entered it runs its full hold regardless of vb_s.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         hold_q      <= '0;
         tile_we_q   <= 1'b0;
         tile_addr_q <= '0;
         tile_data_q <= '0;
      end else begin
         case (state_q)
            S_IDLE:    state_q <= empty ? S_IDLE : S_WAIT_VB;
            S_WAIT_VB: if (pop) begin
               state_q                    <= S_WRITE;
               tile_we_q                  <= 1'b1;
               hold_q                     <= HW'(WR_HOLD - 1);
               {tile_addr_q, tile_data_q} <= head;
            end
            S_WRITE:   if (hold_q == '0) begin
               state_q   <= S_IDLE;
               tile_we_q <= 1'b0;
            end else begin
               hold_q <= hold_q - HW'(1);
            end
            default:   state_q <= S_IDLE;
         endcase
      end
   end
   assign bus.mem_ready = ready_q;
   assign bus.mem_rdata = rdata_q;
   assign tile_we       = tile_we_q;
   assign tile_addr     = tile_addr_q;
   assign tile_data     = tile_data_q;
   assign user_block_u  = user_u_q;
   assign user_block_d  = user_d_q;
   assign irq_empty     = empty && state_q == S_IDLE;
endmodule

// File: tb/tb_hdmi_tile_wr_ctrl.sv
// tb_hdmi_tile_wr_ctrl: directed bench for hdmi_tile_wr_ctrl (ADDR_W=16, FIFO_DEPTH=8, WR_HOLD=2).
module tb_hdmi_tile_wr_ctrl;
   import hdmi_pkg::*;
   logic        sys_clk = 1'b0;
   logic        rst = 1'b1;
   logic        vblank_in = 1'b0;
   logic        tile_we, irq_empty;
   logic [15:0] tile_addr;
   logic [31:0] tile_data, user_block_u, user_block_d;
   int          passed = 0, failed = 0, total = 0, we_cycles = 0;
   logic        we_prev = 1'b0;
   logic [47:0] cap[$];
   hdmi_tile_wr_ctrl_if bus();
   hdmi_tile_wr_ctrl #(.ADDR_W(16), .FIFO_DEPTH(8), .WR_HOLD(2)) dut (
      .sys_clk      (sys_clk),
      .rst          (rst),
      .bus          (bus),
      .vblank_in    (vblank_in),
      .tile_we      (tile_we),
      .tile_addr    (tile_addr),
      .tile_data    (tile_data),
      .user_block_u (user_block_u),
      .user_block_d (user_block_d),
      .irq_empty    (irq_empty)
   );
   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) begin
      #1;
      if (tile_we) we_cycles++;
      if (tile_we && !we_prev) cap.push_back({tile_addr, tile_data});
      we_prev = tile_we;
   end
   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1);
   end
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic cyc(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask
   task automatic start_req(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
      @(negedge sys_clk);
      bus.mem_valid = 1'b1;
      bus.mem_addr  = a;
      bus.mem_wdata = d;
      bus.mem_wstrb = s;
   endtask
   task automatic wait_ack(input int max, output logic ok, output logic [31:0] rd);
      ok = 1'b0;
      rd = '0;
      for (int i = 0; i < max && !ok; i++) begin
         @(posedge sys_clk);
         #1;
         if (bus.mem_ready) begin
            ok = 1'b1;
            rd = bus.mem_rdata;
         end
      end
      if (ok) bus.mem_valid = 1'b0;
   endtask
   task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
      logic ok;
      logic [31:0] rd;
      start_req(a, d, s);
      wait_ack(50, ok, rd);
      chk("wr_ack", {63'b0, ok}, 64'd1);
   endtask
   task automatic rdr(input string tag, input logic [4:0] a, input logic [31:0] exp);
      logic ok;
      logic [31:0] rd;
      start_req(a, 32'b0, 4'b0);
      wait_ack(50, ok, rd);
      chk(tag, {31'b0, ok, rd}, {31'b0, 1'b1, exp});
   endtask
   task automatic wait_idle(input string tag);
      logic ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(posedge sys_clk);
         #1;
         ok = irq_empty && !tile_we;
      end
      chk(tag, {63'b0, ok}, 64'd1);
   endtask
   initial begin
      logic ok;
      logic [31:0] rd;
      int w0;
      bus.mem_valid = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.mem_wstrb = '0;
      cyc(3);
      @(negedge sys_clk);
      rst = 1'b0;
      chk("rst_tile_we", {63'b0, tile_we}, 64'd0);
      chk("rst_tile_addr", {48'b0, tile_addr}, 64'd0);
      chk("rst_tile_data", {32'b0, tile_data}, 64'd0);
      chk("rst_user_u", {32'b0, user_block_u}, 64'd0);
      chk("rst_user_d", {32'b0, user_block_d}, 64'd0);
      chk("rst_irq_empty", {63'b0, irq_empty}, 64'd1);
      chk("rst_mem_ready", {63'b0, bus.mem_ready}, 64'd0);
      chk("rst_mem_rdata", {32'b0, bus.mem_rdata}, 64'd0);
      rdr("status_reset", OFF_STATUS, 32'h0000_0200);
      rdr("addr_reset", OFF_ADDR, 32'h0);
      rdr("ctrl_reset", OFF_CTRL, 32'h0);
      // auto-increment burst of three
      wr(OFF_ADDR, 32'h10, 4'hF);
      wr(OFF_CTRL, 32'h1, 4'hF);
      cap.delete();
      w0 = we_cycles;
      wr(OFF_DATA, 32'hA, 4'hF);
      wr(OFF_DATA, 32'hB, 4'hF);
      wr(OFF_DATA, 32'hC, 4'hF);
      wait_idle("idle_burst3");
      chk("burst3_count", 64'(cap.size()), 64'd3);
      chk("burst3_e0", {16'b0, cap[0]}, {16'b0, 16'h0010, 32'hA});
      chk("burst3_e1", {16'b0, cap[1]}, {16'b0, 16'h0011, 32'hB});
      chk("burst3_e2", {16'b0, cap[2]}, {16'b0, 16'h0012, 32'hC});
      chk("burst3_we_cycles", 64'(we_cycles - w0), 64'd6);
      rdr("addr_after_inc", OFF_ADDR, 32'h13);
      // push-to-write latency, auto-inc off
      wr(OFF_CTRL, 32'h0, 4'hF);
      wr(OFF_DATA, 32'h55, 4'hF);
      cyc(1);
      chk("lat_n2", {63'b0, tile_we}, 64'd0);
      cyc(1);
      chk("lat_n3", {63'b0, tile_we}, 64'd1);
      chk("lat_addr", {48'b0, tile_addr}, 64'h13);
      chk("lat_data", {32'b0, tile_data}, 64'h55);
      cyc(1);
      chk("lat_n4", {63'b0, tile_we}, 64'd1);
      cyc(1);
      chk("lat_n5", {63'b0, tile_we}, 64'd0);
      wait_idle("idle_lat");
      rdr("addr_no_inc", OFF_ADDR, 32'h13);
      // vblank-gated single write
      wr(OFF_CTRL, 32'h2, 4'hF);
      cap.delete();
      wr(OFF_DATA, 32'h77, 4'hF);
      cyc(10);
      chk("vb_hold_nowrite", 64'(cap.size()), 64'd0);
      chk("vb_hold_irq", {63'b0, irq_empty}, 64'd0);
      rdr("vb_hold_status", OFF_STATUS, 32'h0000_0401);
      @(negedge sys_clk);
      vblank_in = 1'b1;
      cyc(1);
      chk("vb_e1", {63'b0, tile_we}, 64'd0);
      cyc(1);
      chk("vb_e2", {63'b0, tile_we}, 64'd0);
      cyc(1);
      chk("vb_e3", {63'b0, tile_we}, 64'd1);
      wait_idle("idle_vb");
      chk("vb_entry", {16'b0, cap[0]}, {16'b0, 16'h0013, 32'h77});
      @(negedge sys_clk);
      vblank_in = 1'b0;
      cyc(3);
      // fill FIFO while the drain is held, ninth write stalls
      wr(OFF_ADDR, 32'h100, 4'hF);
      wr(OFF_CTRL, 32'h3, 4'hF);
      cap.delete();
      for (int i = 0; i < 8; i++) wr(OFF_DATA, 32'h900 + 32'(i), 4'hF);
      start_req(OFF_DATA, 32'h908, 4'hF);
      wait_ack(10, ok, rd);
      chk("full_stall", {63'b0, ok}, 64'd0);
      chk("full_irq", {63'b0, irq_empty}, 64'd0);
      @(negedge sys_clk);
      vblank_in = 1'b1;
      wait_ack(20, ok, rd);
      bus.mem_valid = 1'b0;
      chk("full_release_ack", {63'b0, ok}, 64'd1);
      wait_idle("idle_full");
      chk("full_count", 64'(cap.size()), 64'd9);
      for (int i = 0; i < 9; i++)
         chk($sformatf("full_e%0d", i), {16'b0, cap[i]}, {16'b0, 16'h100 + 16'(i), 32'h900 + 32'(i)});
      rdr("addr_after_full", OFF_ADDR, 32'h109);
      @(negedge sys_clk);
      vblank_in = 1'b0;
      wr(OFF_CTRL, 32'h0, 4'hF);
      // byte strobes and unmapped offsets
      wr(OFF_USER_U, 32'hFFFF_FFFF, 4'hF);
      cyc(1);
      chk("user_u_full", {32'b0, user_block_u}, 64'hFFFF_FFFF);
      wr(OFF_USER_U, 32'h1234_5678, 4'b0011);
      cyc(1);
      chk("user_u_strb", {32'b0, user_block_u}, 64'hFFFF_5678);
      rdr("user_u_read", OFF_USER_U, 32'hFFFF_5678);
      wr(OFF_USER_D, 32'hCAFE_BABE, 4'hF);
      cyc(1);
      chk("user_d", {32'b0, user_block_d}, 64'hCAFE_BABE);
      wr(OFF_ADDR, 32'hABCD_1234, 4'b0010);
      rdr("addr_strb", OFF_ADDR, 32'h1209);
      rdr("data_read_zero", OFF_DATA, 32'h0);
      wr(5'h18, 32'hDEAD_BEEF, 4'hF);
      rdr("unmapped_read", 5'h18, 32'h0);
      rdr("user_d_intact", OFF_USER_D, 32'hCAFE_BABE);
      // address wrap on auto-increment
      wr(OFF_ADDR, 32'hFFFF, 4'hF);
      wr(OFF_CTRL, 32'h1, 4'hF);
      cap.delete();
      wr(OFF_DATA, 32'h1, 4'hF);
      wait_idle("idle_wrap");
      chk("wrap_entry", {16'b0, cap[0]}, {16'b0, 16'hFFFF, 32'h1});
      rdr("addr_wrap", OFF_ADDR, 32'h0);
      // reset in the middle of a write
      wr(OFF_CTRL, 32'h0, 4'hF);
      wr(OFF_ADDR, 32'h20, 4'hF);
      wr(OFF_DATA, 32'h1, 4'hF);
      wr(OFF_DATA, 32'h2, 4'hF);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(posedge sys_clk);
         #1;
         ok = tile_we;
      end
      chk("mid_we_seen", {63'b0, ok}, 64'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_we", {63'b0, tile_we}, 64'd0);
      chk("mid_rst_irq", {63'b0, irq_empty}, 64'd1);
      w0 = we_cycles;
      cyc(2);
      @(negedge sys_clk);
      rst = 1'b0;
      cyc(10);
      chk("mid_rst_no_write", 64'(we_cycles - w0), 64'd0);
      rdr("mid_rst_status", OFF_STATUS, 32'h0000_0200);
      rdr("mid_rst_addr", OFF_ADDR, 32'h0);
      chk("mid_rst_user_u", {32'b0, user_block_u}, 64'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/hdmi_tile_wr_ctrl.md
# hdmi_tile_wr_ctrl

CPU-facing write controller for the HDMI tile/pattern RAM. Decodes the PicoRV32 native memory bus into a small register window, queues tile writes (address + data) in a command FIFO and drains it into the pattern generator's tile-RAM write port, optionally only during vertical blanking. It also holds the two `user_block` words, so the video path no longer relies on combinational byte-latch feedback.

## Interface
- `ADDR_W`, 16: tile RAM address width.
- `FIFO_DEPTH`, 8: command FIFO entries; must be a power of 2, minimum 2.
- `WR_HOLD`, 2: cycles `tile_we` stays high per write; minimum 1.
- `sys_clk`, in, 1: system clock (50 MHz). Single clock domain.
- `rst`, in, 1: asynchronous, active-high reset.
- `mem_valid`, in, 1: bus request.
- `mem_ready`, out, 1: one-cycle acknowledge.
- `mem_addr`, in, 5: byte offset within the window; bits [1:0] are ignored.
- `mem_wdata`, in, 32: write data.
- `mem_wstrb`, in, 4: byte strobes. All zero means a read.
- `mem_rdata`, out, 32: read data; valid while `mem_ready` is high.
- `vblank_in`, in, 1: vertical blank from the pixel domain (asynchronous).
- `tile_we`, out, 1: tile RAM write enable.
- `tile_addr`, out, ADDR_W: tile RAM address.
- `tile_data`, out, 32: tile RAM data.
- `user_block_u`, out, 32: user block, upper word.
- `user_block_d`, out, 32: user block, lower word.
- `irq_empty`, out, 1: level signal, high when the FIFO is empty and the FSM is IDLE.

## Operation
- Register map (byte offsets):
  - 0x00 ADDR (R/W, ADDR_W bits).
  - 0x04 DATA (W): pushes {ADDR, written word} into the FIFO. Reads return 0.
  - 0x08 CTRL (R/W): bit0 `AUTO_INC`, bit1 `VBLANK_ONLY`.
  - 0x0C STATUS (RO): [7:0] FIFO level, bit8 full, bit9 empty, bit10 busy (FSM not IDLE).
  - 0x10 USER_U (R/W).
  - 0x14 USER_D (R/W).
  - Writes to 0x18–0x1C are ignored. Reads of 0x18–0x1C return 0.
- Byte strobes apply per byte to ADDR, CTRL, USER_U and USER_D.
- A DATA write with any strobe set pushes the full 32-bit `mem_wdata`. Unstrobed bytes are not masked.
- With `AUTO_INC` set, ADDR increments by 1 in the same cycle as the push and wraps modulo 2^ADDR_W.
- FIFO full on a DATA write: `mem_ready` is withheld until a slot frees. The push and the ack then happen in the same cycle. Any other access is never stalled.
- `vblank_in` passes through a 2-FF synchronizer to give `vb_s`.
- Drain FSM:
  - IDLE → WAIT_VB when the FIFO is not empty. WAIT_VB pops the head entry into the `tile_addr`/`tile_data` output registers.
  - WAIT_VB → WRITE when `VBLANK_ONLY`=0 or `vb_s`=1.
  - WRITE: `tile_we`=1 for WR_HOLD cycles, then → IDLE.
  - The WAIT_VB check is taken once per entry. A write that has started always finishes its WR_HOLD, even if `vb_s` falls.
- Simultaneous push and pop is legal. The level is unchanged and the full flag does not block that push.
- Reset mid-operation: the FIFO is flushed, the FSM goes to IDLE, and any write in progress is abandoned.

## Timing
- Values after reset:
  - `mem_ready`=0, `mem_rdata`=0.
  - `tile_we`=0, `tile_addr`=0, `tile_data`=0.
  - `user_block_u`=0, `user_block_d`=0.
  - ADDR=0, CTRL=0.
  - `irq_empty`=1.
- Bus latency: `mem_ready` rises in the cycle after `mem_valid` is sampled (unstalled case). The bus drops `mem_valid` after the ack. Register effects are visible the cycle after the ack.
- Push to `tile_we` with `VBLANK_ONLY`=0 and an empty FIFO:
  - Push at cycle n.
  - IDLE sees not-empty at n+1.
  - WAIT_VB pops at n+2.
  - `tile_we` is high from n+3 to n+2+WR_HOLD.
- Throughput: one tile write every WR_HOLD+2 cycles.
- `vb_s` lags `vblank_in` by 2 cycles.
- `user_block_*` update in the cycle after the acked write.

## Structure
- Shared package `hdmi_pkg`:
  - Register offsets.
  - CTRL/STATUS bit indices.
  - FSM state encoding (IDLE, WAIT_VB, WRITE).
- Sub-module `sync_fifo`: parameters for width (ADDR_W+32) and depth; outputs full, empty and level. Reused elsewhere.
- The 2-FF synchronizer and the register decode are inline.

## Test plan
- Reset, then read STATUS → 0x0000_0200 (empty). `irq_empty`=1.
- ADDR=0x0010, CTRL=1, three DATA writes (0xA, 0xB, 0xC) → three `tile_we` pulses at addresses 0x10/0x11/0x12 carrying 0xA/0xB/0xC. ADDR reads back 0x13.
- CTRL=2 and `vblank_in`=0, one DATA write → no `tile_we` and busy=1. Raise `vblank_in` → `tile_we` follows 3 cycles later.
- Nine back-to-back DATA writes with DEPTH=8 and `VBLANK_ONLY` holding the drain → 9th write gets no `mem_ready`. Release vblank → 9th write acks. All 9 writes come out in order.
- USER_U write 0x12345678 with strobe 0b0011, after a previous 0xFFFFFFFF → `user_block_u`=0xFFFF5678.
- Assert `rst` while `tile_we` is high → `tile_we`=0 immediately, FIFO empty, and no write after release.
